// File: rtl/colour_arbiter.sv
// colour_arbiter: round-robin sequencer sharing one registered RGB converter
// between N_REQ requesters. Issues the winning colour, waits out the
// converter latency, captures the result and pulses a one-hot grant.
module colour_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CONV_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   colour_in,
  output logic [N_REQ-1:0]     grant,
  output logic [23:0]          rgb_out,
  output logic                 busy,
  output logic                 conv_enable,
  output logic [2:0]           conv_colour,
  input  logic [23:0]          conv_rgb
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam logic [3:0] CNT_INIT = 4'(CONV_LAT);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [SEL_W-1:0]    sel_r, sel_nx_s;
  logic [SEL_W-1:0]    ptr_r, ptr_nx_s;
  logic [SEL_W-1:0]    win_s;
  logic [3:0]          cnt_r, cnt_nx_s;
  logic [N_REQ-1:0]    grant_r, grant_nx_s;
  logic [23:0]         rgb_r, rgb_nx_s;
  logic                busy_r, busy_nx_s;
  logic                en_r, en_nx_s;
  logic [2:0]          colour_r, colour_nx_s;

  // First set request bit searching from p upward, wrapping mod N_REQ.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] w;
    logic             found;
    int               idx;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        w     = SEL_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] one_hot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Successor index mod N_REQ, so the served requester drops to lowest priority.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] s);
    if (s == LAST_IDX) begin
      return {SEL_W{1'b0}};
    end else begin
      return s + SEL_W'(1);
    end
  endfunction

  assign win_s = rr_pick(req, ptr_r);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, count down in WAIT, one DONE cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output/datapath next values; colour is latched at issue and held through WAIT.
  always_comb begin
    sel_nx_s    = sel_r;
    ptr_nx_s    = ptr_r;
    cnt_nx_s    = cnt_r;
    grant_nx_s  = grant_r;
    rgb_nx_s    = rgb_r;
    en_nx_s     = en_r;
    colour_nx_s = colour_r;
    busy_nx_s   = (state_nx_s != IDLE);
    case (state_r)
      IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          sel_nx_s    = win_s;
          colour_nx_s = colour_in[3*win_s +: 3];
          en_nx_s     = 1'b1;
          cnt_nx_s    = CNT_INIT;
        end else begin
          en_nx_s     = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          rgb_nx_s   = conv_rgb;
          grant_nx_s = one_hot(sel_r);
          en_nx_s    = 1'b0;
        end else begin
          cnt_nx_s   = cnt_r - 4'd1;
        end
      end
      DONE: begin
        grant_nx_s = {N_REQ{1'b0}};
        ptr_nx_s   = next_idx(sel_r);
      end
      default: begin
        grant_nx_s = {N_REQ{1'b0}};
        en_nx_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r    <= {SEL_W{1'b0}};
      ptr_r    <= {SEL_W{1'b0}};
      cnt_r    <= 4'd0;
      grant_r  <= {N_REQ{1'b0}};
      rgb_r    <= 24'd0;
      busy_r   <= 1'b0;
      en_r     <= 1'b0;
      colour_r <= 3'd0;
    end else begin
      sel_r    <= sel_nx_s;
      ptr_r    <= ptr_nx_s;
      cnt_r    <= cnt_nx_s;
      grant_r  <= grant_nx_s;
      rgb_r    <= rgb_nx_s;
      busy_r   <= busy_nx_s;
      en_r     <= en_nx_s;
      colour_r <= colour_nx_s;
    end
  end

  assign grant       = grant_r;
  assign rgb_out     = rgb_r;
  assign busy        = busy_r;
  assign conv_enable = en_r;
  assign conv_colour = colour_r;

endmodule
